program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 29 ++
 rtl/program_loader_if.sv | 34 +++
 rtl/program_loader_sync_2ff.sv | 34 +++
 rtl/program_loader.sv | 181 ++++++++++++++++++
 tb/tb_program_loader.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/program_loader_pkg.sv
// -----------------------------------------------------------------------------
// program_loader_pkg
// Shared CPU-side definitions for the boot program loader: frame start marker,
// RAM depth, RAM address width and the loader state encoding.
// -----------------------------------------------------------------------------
package program_loader_pkg;

    localparam logic [7:0] HDR_BYTE  = 8'hA5;
    localparam int         RAM_BYTES = 16;
    localparam int         ADDR_W    = 4;
    // Remaining-byte counter must be able to hold RAM_BYTES itself.
    localparam int         CNT_W     = 5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_HDR  = 3'd1,
        ST_WAIT_CNT  = 3'd2,
        ST_WAIT_DATA = 3'd3,
        ST_WAIT_SUM  = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERROR     = 3'd6
    } loader_state_e;

    // Running frame checksum: plain 8-bit sum, wrapping mod 256.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// -----------------------------------------------------------------------------
// program_loader_if
// Host handshake and RAM write bus of the program loader.
//   load_mode, in_strobe, in_data : host -> loader (asynchronous host side)
//   ack                           : loader -> host four-phase acknowledge
//   ram_addr, ram_data, ram_we    : loader -> RAM write port
//   cpu_hold_n, done, error       : loader status / CPU reset hold
// Modports: slave = loader side, master = host/RAM side.
// -----------------------------------------------------------------------------
interface program_loader_if;
    import program_loader_pkg::*;

    logic              load_mode;
    logic              in_strobe;
    logic [7:0]        in_data;
    logic              ack;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_data;
    logic              ram_we;
    logic              cpu_hold_n;
    logic              done;
    logic              error;

    modport slave (
        input  load_mode, in_strobe, in_data,
        output ack, ram_addr, ram_data, ram_we, cpu_hold_n, done, error
    );

    modport master (
        output load_mode, in_strobe, in_data,
        input  ack, ram_addr, ram_data, ram_we, cpu_hold_n, done, error
    );

endinterface

// File: rtl/program_loader_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for asynchronous level inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset (clears both stages)
//   i_d   : asynchronous input
//   o_q   : synchronized output, two clk edges of latency
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Metastability stage followed by the settled stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= {WIDTH{1'b0}};
            r_sync <= {WIDTH{1'b0}};
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Receives a boot frame from an asynchronous host over a four-phase strobe/ack
// handshake and writes it into program RAM while holding the CPU in reset.
// Frame: HDR_BYTE, count N (1..RAM_BYTES), N data bytes, 8-bit sum of data.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : program_loader_if.slave (host handshake, RAM write, status)
// Parameters: RAM_BYTES (RAM depth), HDR_BYTE (frame start marker).
// -----------------------------------------------------------------------------
module program_loader #(
    parameter int         RAM_BYTES = program_loader_pkg::RAM_BYTES,
    parameter logic [7:0] HDR_BYTE  = program_loader_pkg::HDR_BYTE
) (
    input  logic               clk,
    input  logic               rst_n,
    program_loader_if.slave    bus
);
    import program_loader_pkg::*;

    logic              w_load_s;
    logic              w_strobe_s;
    logic              r_strobe_d;
    logic              w_abort;
    logic              w_capture;
    logic [7:0]        w_byte;

    loader_state_e     r_state,    w_state_nxt;
    logic [ADDR_W-1:0] r_addr_cnt, w_addr_cnt_nxt;
    logic [CNT_W-1:0]  r_remain,   w_remain_nxt;
    logic [7:0]        r_sum,      w_sum_nxt;
    logic              r_ack,      w_ack_nxt;
    logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_nxt;
    logic [7:0]        r_ram_data, w_ram_data_nxt;
    logic              r_ram_we,   w_ram_we_nxt;
    logic              r_cpu_hold_n;
    logic              r_done;
    logic              r_error;

    sync_2ff #(.WIDTH(1)) u_sync_load (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.load_mode),
        .o_q   (w_load_s)
    );

    sync_2ff #(.WIDTH(1)) u_sync_strobe (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.in_strobe),
        .o_q   (w_strobe_s)
    );

    // Next-state and datapath decode; abort outranks any strobe edge.
    always_comb begin
        w_byte         = bus.in_data;
        w_abort        = (r_state != ST_IDLE) && !w_load_s;
        // in_data is stable for the whole strobe, so it is safe to sample
        // directly once the synchronized strobe edge is seen.
        w_capture      = w_strobe_s && !r_strobe_d && !r_ack && !w_abort;
        w_state_nxt    = r_state;
        w_addr_cnt_nxt = r_addr_cnt;
        w_remain_nxt   = r_remain;
        w_sum_nxt      = r_sum;
        w_ram_addr_nxt = r_ram_addr;
        w_ram_data_nxt = r_ram_data;
        w_ram_we_nxt   = 1'b0;

        if (w_capture) begin
            w_ack_nxt = 1'b1;
        end else if (!w_strobe_s) begin
            w_ack_nxt = 1'b0;
        end else begin
            w_ack_nxt = r_ack;
        end

        if (w_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load_s) begin
                        w_state_nxt = ST_WAIT_HDR;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_WAIT_HDR: begin
                    if (w_capture && (w_byte == HDR_BYTE)) begin
                        w_state_nxt = ST_WAIT_CNT;
                    end else begin
                        w_state_nxt = ST_WAIT_HDR;
                    end
                end
                ST_WAIT_CNT: begin
                    if (!w_capture) begin
                        w_state_nxt = ST_WAIT_CNT;
                    end else if ((w_byte == 8'd0) || (int'(w_byte) > RAM_BYTES)) begin
                        w_state_nxt = ST_ERROR;
                    end else begin
                        w_state_nxt    = ST_WAIT_DATA;
                        w_remain_nxt   = w_byte[CNT_W-1:0];
                        w_addr_cnt_nxt = {ADDR_W{1'b0}};
                        w_sum_nxt      = 8'h00;
                    end
                end
                ST_WAIT_DATA: begin
                    if (w_capture) begin
                        w_ram_we_nxt   = 1'b1;
                        w_ram_addr_nxt = r_addr_cnt;
                        w_ram_data_nxt = w_byte;
                        w_sum_nxt      = csum_add(r_sum, w_byte);
                        // Last byte: leave the address where it is so it never wraps.
                        if (r_remain == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            w_state_nxt  = ST_WAIT_SUM;
                            w_remain_nxt = {CNT_W{1'b0}};
                        end else begin
                            w_state_nxt    = ST_WAIT_DATA;
                            w_remain_nxt   = r_remain - {{(CNT_W-1){1'b0}}, 1'b1};
                            w_addr_cnt_nxt = r_addr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        w_state_nxt = ST_WAIT_DATA;
                    end
                end
                ST_WAIT_SUM: begin
                    if (!w_capture) begin
                        w_state_nxt = ST_WAIT_SUM;
                    end else if (w_byte == r_sum) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_ERROR;
                    end
                end
                ST_DONE:  w_state_nxt = ST_DONE;
                ST_ERROR: w_state_nxt = ST_ERROR;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, datapath and registered outputs; status follows the next state
    // so it lines up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_strobe_d   <= 1'b0;
            r_addr_cnt   <= {ADDR_W{1'b0}};
            r_remain     <= {CNT_W{1'b0}};
            r_sum        <= 8'h00;
            r_ack        <= 1'b0;
            r_ram_addr   <= {ADDR_W{1'b0}};
            r_ram_data   <= 8'h00;
            r_ram_we     <= 1'b0;
            r_cpu_hold_n <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_strobe_d   <= w_strobe_s;
            r_addr_cnt   <= w_addr_cnt_nxt;
            r_remain     <= w_remain_nxt;
            r_sum        <= w_sum_nxt;
            r_ack        <= w_ack_nxt;
            r_ram_addr   <= w_ram_addr_nxt;
            r_ram_data   <= w_ram_data_nxt;
            r_ram_we     <= w_ram_we_nxt;
            r_cpu_hold_n <= (w_state_nxt == ST_IDLE);
            r_done       <= (w_state_nxt == ST_DONE);
            r_error      <= (w_state_nxt == ST_ERROR);
        end
    end

    assign bus.ack        = r_ack;
    assign bus.ram_addr   = r_ram_addr;
    assign bus.ram_data   = r_ram_data;
    assign bus.ram_we     = r_ram_we;
    assign bus.cpu_hold_n = r_cpu_hold_n;
    assign bus.done       = r_done;
    assign bus.error      = r_error;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
// Directed self-checking bench for program_loader: drives host frames through
// the four-phase handshake and checks RAM writes and status against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_program_loader;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic [3:0] wr_addr[$];
    logic [7:0] wr_data[$];

    program_loader_if bus();

    program_loader #(
        .RAM_BYTES (16),
        .HDR_BYTE  (8'hA5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every RAM write pulse, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.ram_we === 1'b1) begin
            wr_addr.push_back(bus.ram_addr);
            wr_data.push_back(bus.ram_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One four-phase byte transfer; returns negedges from strobe rise to ack.
    task automatic send_byte(input logic [7:0] b, output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        bus.in_data   = b;
        bus.in_strobe = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.ack === 1'b1) begin
                got = 1'b1;
                lat = i;
                break;
            end
        end
        chk("ack_rise", 32'(got), 32'd1);
        bus.in_strobe = 1'b0;
        got = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.ack === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        chk("ack_fall", 32'(got), 32'd1);
    endtask

    task automatic send(input logic [7:0] b);
        int lat;
        send_byte(b, lat);
    endtask

    task automatic start_load();
        wr_addr.delete();
        wr_data.delete();
        bus.load_mode = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic end_load(input string tag);
        bus.load_mode = 1'b0;
        repeat (4) @(negedge clk);
        chk({tag, "_hold_rel"}, 32'(bus.cpu_hold_n), 32'd1);
        chk({tag, "_done_clr"}, 32'(bus.done), 32'd0);
        chk({tag, "_err_clr"},  32'(bus.error), 32'd0);
    endtask

    initial begin
        int lat;
        int snap;
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.load_mode = 1'b0;
        bus.in_strobe = 1'b0;
        bus.in_data   = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ack",  32'(bus.ack), 32'd0);
        chk("rst_we",   32'(bus.ram_we), 32'd0);
        chk("rst_hold", 32'(bus.cpu_hold_n), 32'd1);
        chk("rst_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst_data", 32'(bus.ram_data), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err",  32'(bus.error), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good three-byte frame.
        start_load();
        chk("load_hold", 32'(bus.cpu_hold_n), 32'd0);
        send_byte(8'hA5, lat);
        chk("cap_latency", 32'(lat), 32'd3);
        send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h66);
        chk("load_nwr", 32'(wr_addr.size()), 32'd3);
        if (wr_addr.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("load_addr", 32'(wr_addr[i]), 32'(i));
            end
            chk("load_d0", 32'(wr_data[0]), 32'h11);
            chk("load_d1", 32'(wr_data[1]), 32'h22);
            chk("load_d2", 32'(wr_data[2]), 32'h33);
        end
        chk("load_done",  32'(bus.done), 32'd1);
        chk("load_err",   32'(bus.error), 32'd0);
        chk("load_hold2", 32'(bus.cpu_hold_n), 32'd0);
        chk("hold_addr",  32'(bus.ram_addr), 32'd2);
        chk("hold_data",  32'(bus.ram_data), 32'h33);
        send(8'h44);
        chk("done_sticky", 32'(bus.done), 32'd1);
        chk("done_nowr",   32'(wr_addr.size()), 32'd3);
        end_load("load");

        // Bad checksum.
        start_load();
        send(8'hA5); send(8'h01); send(8'h7F); send(8'h00);
        chk("bsum_nwr",  32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("bsum_a0", 32'(wr_addr[0]), 32'd0);
            chk("bsum_d0", 32'(wr_data[0]), 32'h7F);
        end
        chk("bsum_err",  32'(bus.error), 32'd1);
        chk("bsum_done", 32'(bus.done), 32'd0);
        end_load("bsum");

        // Bad count: zero, then 17.
        start_load();
        send(8'hA5); send(8'h00);
        chk("cnt0_err", 32'(bus.error), 32'd1);
        chk("cnt0_nwr", 32'(wr_addr.size()), 32'd0);
        end_load("cnt0");
        start_load();
        send(8'hA5); send(8'h11);
        chk("cnt17_err", 32'(bus.error), 32'd1);
        chk("cnt17_nwr", 32'(wr_addr.size()), 32'd0);
        end_load("cnt17");

        // Junk ahead of the header.
        start_load();
        send(8'h00); send(8'hFF);
        chk("junk_nwr", 32'(wr_addr.size()), 32'd0);
        send(8'hA5); send(8'h01); send(8'h05); send(8'h05);
        chk("junk_nwr2", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("junk_d0", 32'(wr_data[0]), 32'h05);
        end
        chk("junk_done", 32'(bus.done), 32'd1);
        end_load("junk");

        // Abort mid-frame.
        start_load();
        send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
        end_load("abort");
        chk("abort_nwr", 32'(wr_addr.size()), 32'd2);
        send(8'h03);
        chk("abort_later", 32'(wr_addr.size()), 32'd2);

        // Strobe edge coinciding with the load_mode drop is ignored.
        start_load();
        send(8'hA5); send(8'h02); send(8'h01);
        bus.in_data   = 8'h09;
        bus.in_strobe = 1'b1;
        bus.load_mode = 1'b0;
        repeat (6) @(negedge clk);
        chk("race_nwr", 32'(wr_addr.size()), 32'd1);
        chk("race_ack", 32'(bus.ack), 32'd0);
        chk("race_hold", 32'(bus.cpu_hold_n), 32'd1);
        bus.in_strobe = 1'b0;
        repeat (4) @(negedge clk);

        // Reset during the write of data byte 2.
        start_load();
        send(8'hA5); send(8'h03); send(8'hAA);
        bus.in_data   = 8'hBB;
        bus.in_strobe = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.ram_we === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk("rstw_seen", 32'(lat != 0), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstw_we",   32'(bus.ram_we), 32'd0);
        chk("rstw_addr", 32'(bus.ram_addr), 32'd0);
        chk("rstw_data", 32'(bus.ram_data), 32'd0);
        chk("rstw_hold", 32'(bus.cpu_hold_n), 32'd1);
        chk("rstw_ack",  32'(bus.ack), 32'd0);
        bus.in_strobe = 1'b0;
        bus.load_mode = 1'b0;
        snap = wr_addr.size();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("rstw_nowr", 32'(wr_addr.size()), 32'(snap));
        chk("rstw_idle", 32'(bus.cpu_hold_n), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
